multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execution-stage ALU that consumes the 4-bit ALUOperation code from the ALU control decoder, together with register operands and shamt.
- Logical, arithmetic, LUI and pass-through operations complete in one clock.
- SLL/SRL use a serial shifter, one bit per clock, instead of a barrel shifter.
- A start/busy/done handshake lets the core stall on long shifts. Result and Zero feed the writeback mux and branch logic.

Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width (max shift DATA_WIDTH-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; operands sampled on the clk edge where start=1 and busy=0
- ALUOperation  in  4  operation code
- A  in  DATA_WIDTH  operand rs
- B  in  DATA_WIDTH  operand rt / immediate
- shamt  in  SHAMT_WIDTH  shift amount
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse: ALUResult/Zero valid
- ALUResult  out  DATA_WIDTH  registered result, held until the next accepted start
- Zero  out  1  registered, (ALUResult == 0)
- IllegalOp  out  1  registered, set with done when the code is unsupported

Behaviour:
- Opcodes:
  - AND=0000: A&B
  - OR=0001: A|B
  - NOR=0010: ~(A|B)
  - ADD=0011: A+B
  - SUB=0100: A-B
  - LUI=0101: {B[15:0],16'b0}
  - JAL=0110: pass B
  - SRL=0111: B>>shamt, logical
  - SLL=1000: B<<shamt
  - JR=1001: pass A
  - 1010-1111: result 0, IllegalOp=1
- ADD/SUB wrap modulo 2^DATA_WIDTH. No overflow flag and no exception.
- Reset (async, reset=0):
  - state=IDLE, busy=0, done=0, ALUResult=0, Zero=1, IllegalOp=0, counter=0.
- FSM states: IDLE, SHIFT.
- IDLE, start=1:
  - Non-shift op, or shift with shamt=0: compute, register ALUResult/Zero/IllegalOp, pulse done. Stay IDLE. Latency 1 clock.
  - Shift op with shamt=n>0: load accumulator=B and counter=n, set busy, go to SHIFT.
- SHIFT, each clock:
  - Shift the accumulator 1 bit (zero fill; direction latched at start) and decrement the counter.
  - When the counter reaches 0 on this edge: register the result, pulse done, clear busy, return to IDLE.
  - Total latency n+1 clocks from the start edge. shamt=31 gives 32 clocks.
- ALUOperation, A, B and shamt are latched at accept. Input changes during SHIFT have no effect.
- start while busy=1 is ignored (not queued). The requester must hold start or re-issue after done.
- start in the same cycle done is asserted (IDLE) is accepted normally, which allows back-to-back single-cycle ops.
- done is high for exactly one cycle per accepted start. done and busy are never high together.
- ALUResult/Zero/IllegalOp change only on a done cycle or on reset.
- Reset asserted mid-shift: abort immediately to the reset values. No done pulse for the aborted op.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (AND, OR, NOR, ADD, SUB, LUI, JAL, SRL, SLL, JR), also used by the ALU control decoder.
  - FSM state encoding.
  - DATA_WIDTH/SHAMT_WIDTH defaults.
- One natural sub-module, serial_shifter: accumulator, down-counter, direction bit, load/step/last outputs. Combinational op mux and FSM stay in the top.

Test Plan:
1. Reset low, then release -> busy=0, done=0, ALUResult=0, Zero=1. start with ADD, A=32'h7FFF_FFFF, B=1 -> done 1 clock later, ALUResult=32'h8000_0000, Zero=0.
2. SUB A=5, B=5 -> ALUResult=0, Zero=1, latency 1. Then back-to-back: LUI B=16'h1234 in the done cycle -> next cycle done, ALUResult=32'h1234_0000.
3. SLL B=32'h0000_0001, shamt=31 -> busy for 31 cycles, done on cycle 32, ALUResult=32'h8000_0000. SRL B=32'h8000_0000, shamt=4 -> done cycle 5, ALUResult=32'h0800_0000.
4. SRL shamt=0, B=32'hDEAD_BEEF -> latency 1, ALUResult=32'hDEAD_BEEF, busy never asserts.
5. During a SLL shamt=10: toggle A/B/ALUOperation and pulse start at cycle 3 -> ignored, single done at cycle 11 with the original result. Separately, reset low at cycle 5 -> busy=0 at once, no done, ALUResult=0.
6. ALUOperation=4'b1100 -> done, ALUResult=0, Zero=1, IllegalOp=1. Next op JR A=32'h0040_0020 -> ALUResult=32'h0040_0020, IllegalOp=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU and the ALU control decoder.
// Holds the 4-bit ALUOperation codes, the ALU FSM state encoding and the
// default operand/shift-amount widths.
package alu_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned SHAMT_WIDTH_DEF = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_JR  = 4'b1001;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_t;

endpackage

// File: rtl/multicycle_alu_serial_shifter.sv
// Serial one-bit-per-clock shifter used for SLL/SRL.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            capture data/count/direction
//   step            shift accumulator one bit, decrement counter
//   shift_left      direction captured on load (1 = left, 0 = logical right)
//   data, count     initial accumulator value and number of shifts
//   acc_next        accumulator value after the current step
//   last            this step brings the counter to zero
module multicycle_alu_serial_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   shift_left,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]  acc_next,
  output logic                   last
);

  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      cnt  <= '0;
      left <= 1'b0;
    end else if (load) begin
      acc  <= data;
      cnt  <= count;
      left <= shift_left;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt - SHAMT_WIDTH'(1);
    end
  end

  always_comb begin
    acc_next = left ? (acc << 1) : (acc >> 1);
    last     = step && (cnt == SHAMT_WIDTH'(1));
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle execution-stage ALU. Single-cycle logical/arithmetic/LUI/pass
// operations; SLL/SRL run through a serial shifter with a busy/done handshake.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          request, accepted when not busy
//   ALUOperation   4-bit operation code
//   A, B, shamt    operands and shift amount (latched at accept)
//   busy           shift in progress
//   done           one-cycle pulse, outputs valid
//   ALUResult      registered result
//   Zero           registered (ALUResult == 0)
//   IllegalOp      registered, unsupported opcode
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   IllegalOp
);

  alu_state_t            state, state_nx;
  logic                  is_shift;
  logic                  shift_load;
  logic                  shift_step;
  logic                  shift_last;
  logic                  finish;
  logic                  illegal_imm, illegal_d;
  logic [DATA_WIDTH-1:0] imm_result, result_d, acc_next;

  // Single-cycle result. Shift codes only reach this path with shamt == 0,
  // where the result is B unchanged.
  always_comb begin
    imm_result  = '0;
    illegal_imm = 1'b0;
    case (ALUOperation)
      OP_AND:         imm_result = A & B;
      OP_OR:          imm_result = A | B;
      OP_NOR:         imm_result = ~(A | B);
      OP_ADD:         imm_result = A + B;
      OP_SUB:         imm_result = A - B;
      OP_LUI:         imm_result = B << 16;
      OP_JAL:         imm_result = B;
      OP_SRL, OP_SLL: imm_result = B;
      OP_JR:          imm_result = A;
      default:        illegal_imm = 1'b1;
    endcase
  end

  assign is_shift   = (ALUOperation == OP_SRL) || (ALUOperation == OP_SLL);
  assign shift_step = (state == ST_SHIFT);
  assign busy       = (state == ST_SHIFT);

  multicycle_alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .step       (shift_step),
    .shift_left (ALUOperation == OP_SLL),
    .data       (B),
    .count      (shamt),
    .acc_next   (acc_next),
    .last       (shift_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    shift_load = 1'b0;
    finish     = 1'b0;
    result_d   = imm_result;
    illegal_d  = illegal_imm;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            shift_load = 1'b1;
            state_nx   = ST_SHIFT;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // Final step: take the shifted value directly so done lands on the
        // same edge the counter hits zero.
        if (shift_last) begin
          finish    = 1'b1;
          result_d  = acc_next;
          illegal_d = 1'b0;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      IllegalOp <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        ALUResult <= result_d;
        Zero      <= (result_d == '0);
        IllegalOp <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus randomized
// operations compared against a behavioural model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic        busy, done, Zero, IllegalOp;
  logic [31:0] ALUResult;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  logic [31:0] exp_res;
  logic        exp_ill;
  int          exp_lat;
  bit          exp_shift;

  multicycle_alu #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .shamt        (shamt),
    .busy         (busy),
    .done         (done),
    .ALUResult    (ALUResult),
    .Zero         (Zero),
    .IllegalOp    (IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result from the opcode table, latency = shamt+1 for shifts.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    logic [15:0] lo;
    lo        = b[15:0];
    exp_ill   = 1'b0;
    exp_shift = 1'b0;
    exp_lat   = 1;
    case (op)
      4'd0: exp_res = a & b;
      4'd1: exp_res = a | b;
      4'd2: exp_res = ~(a | b);
      4'd3: exp_res = a + b;
      4'd4: exp_res = a - b;
      4'd5: exp_res = {lo, 16'h0000};
      4'd6: exp_res = b;
      4'd7: begin exp_res = b >> sh; exp_shift = 1'b1; exp_lat = int'(sh) + 1; end
      4'd8: begin exp_res = b << sh; exp_shift = 1'b1; exp_lat = int'(sh) + 1; end
      4'd9: exp_res = a;
      default: begin exp_res = 32'h0; exp_ill = 1'b1; end
    endcase
  endtask

  // Drive a request and let the accept edge pass; leaves us in cycle 1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    model(op, a, b, sh);
    ALUOperation = op;
    A            = a;
    B            = b;
    shamt        = sh;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done; inputs are scrambled and start pulsed while busy.
  task automatic wait_done(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) check_eq({tag, "_busy"}, {31'h0, busy}, 32'h1);
      ALUOperation = 4'($urandom);
      A            = $urandom;
      B            = $urandom;
      shamt        = 5'($urandom);
      start        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'h0, 32'h1);
    end else begin
      check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      check_eq({tag, "_res"}, ALUResult, exp_res);
      check_eq({tag, "_zero"}, {31'h0, Zero}, {31'h0, exp_res == 32'h0});
      check_eq({tag, "_ill"}, {31'h0, IllegalOp}, {31'h0, exp_ill});
      check_eq({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    end
  endtask

  task automatic check_after(input string tag);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, {31'h0, done}, 32'h0);
    check_eq({tag, "_hold"}, ALUResult, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    issue(op, a, b, sh);
    wait_done(tag);
    check_after(tag);
  endtask

  initial begin
    bit any_done;
    reset = 1'b0;
    start = 1'b0;
    ALUOperation = 4'h0;
    A = 32'h0;
    B = 32'h0;
    shamt = 5'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_res", ALUResult, 32'h0);
    check_eq("rst_zero", {31'h0, Zero}, 32'h1);
    check_eq("rst_ill", {31'h0, IllegalOp}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0);

    // SUB then LUI issued in the SUB done cycle.
    issue(4'd4, 32'd5, 32'd5, 5'd0);
    wait_done("sub_eq");
    issue(4'd5, 32'h0, 32'h0000_1234, 5'd0);
    wait_done("lui_b2b");
    check_after("lui_b2b");

    run_op("sll31", 4'd8, 32'h0, 32'h0000_0001, 5'd31);
    run_op("srl4", 4'd7, 32'h0, 32'h8000_0000, 5'd4);
    run_op("srl0", 4'd7, 32'h0, 32'hDEAD_BEEF, 5'd0);
    run_op("sll10", 4'd8, 32'h0, 32'h0000_0F0F, 5'd10);
    run_op("illegal", 4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    run_op("jr", 4'd9, 32'h0040_0020, 32'hFFFF_FFFF, 5'd0);

    // Reset mid-shift: abort, no done.
    issue(4'd8, 32'h0, 32'h0000_0003, 5'd10);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    check_eq("abort_done", {31'h0, done}, 32'h0);
    check_eq("abort_res", ALUResult, 32'h0);
    check_eq("abort_zero", {31'h0, Zero}, 32'h1);
    any_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) any_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) any_done = 1'b1;
    end
    check_eq("abort_no_done", {31'h0, any_done}, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] sh;
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 6));
      run_op("rand", 4'($urandom), $urandom, $urandom, sh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
